// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: level-width sizing and parameter legality checks.
// Latency: n/a (compile-time functions only).
// Backpressure: n/a.
package fifo_pkg;

    // Number of bits needed to count 0..depth inclusive.
    function automatic int fifo_level_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // True when v is a power of two and at least 2.
    function automatic bit fifo_is_pow2(input int v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

    // Legal geometry: power-of-two depth, AF in 1..DEPTH, AE in 0..DEPTH-1.
    function automatic bit fifo_params_ok(input int depth, input int af, input int ae);
        return fifo_is_pow2(depth) && (af >= 1) && (af <= depth) &&
               (ae >= 0) && (ae <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the owner decides when to write.
module fifo_ram #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_stream.sv
// Single-clock valid/ready FIFO with registered FWFT head, thresholds, flush, overflow; SYNC_FIFO_HWM_EN adds a high-water mark.
// Latency: push into an empty FIFO is presented on out_data one cycle later; full-rate push+pop with no bubbles.
// Backpressure: in_ready = !full (a same-edge pop does not free space); out_data holds while out_valid && !out_ready.
module sync_fifo_stream
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 64,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4,
    parameter int LEVEL_W  = fifo_level_w(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LEVEL_W-1:0] level,
    output logic               almost_full,
    output logic               almost_empty,
    output logic               overflow,
    output logic [LEVEL_W-1:0] max_level
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    if (!fifo_params_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_param_check
        $error("sync_fifo_stream: DEPTH must be a power of two >=2, AF_LEVEL in 1..DEPTH, AE_LEVEL in 0..DEPTH-1");
    end

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [WIDTH-1:0]   ram_rd_data;
    logic [LEVEL_W-1:0] level_next;
    logic               full;
    logic               push;
    logic               pop;
    logic               ram_empty;
    logic               load_slot;
    logic               load_ram;
    logic               bypass;
    logic               ram_write;

    assign full      = (level == LEVEL_W'(DEPTH));
    assign in_ready  = !full;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign ram_empty = (wr_ptr == rd_ptr);

    // The head register refills when empty or being taken; the RAM has
    // priority so ordering is kept, otherwise a fresh push skips the RAM.
    assign load_slot = !out_valid || pop;
    assign load_ram  = load_slot && !ram_empty;
    assign bypass    = load_slot && ram_empty && push;
    assign ram_write = push && !bypass;

    assign almost_full  = (level >= LEVEL_W'(AF_LEVEL));
    assign almost_empty = (level <= LEVEL_W'(AE_LEVEL));

    fifo_ram #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_write && !flush),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data (in_data),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (ram_rd_data)
    );

    // Occupancy moves by one only when exactly one of push/pop happens.
    always_comb begin
        level_next = level;
        case ({push, pop})
            2'b10:   level_next = level + LEVEL_W'(1);
            2'b01:   level_next = level - LEVEL_W'(1);
            default: level_next = level;
        endcase
    end

    // RAM pointers and the occupancy counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (ram_write) wr_ptr <= wr_ptr + PTR_W'(1);
            if (load_ram)  rd_ptr <= rd_ptr + PTR_W'(1);
            level <= level_next;
        end
    end

    // Registered head entry: refill from RAM, bypass from input, or go empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load_ram) begin
            out_valid <= 1'b1;
            out_data  <= ram_rd_data;
        end else if (bypass) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (load_slot) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky record of any offer made while full; a flushed push never sets it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (flush) begin
            overflow <= 1'b0;
        end else if (in_valid && !in_ready) begin
            overflow <= 1'b1;
        end
    end

`ifdef SYNC_FIFO_HWM_EN
    logic [LEVEL_W-1:0] hwm;

    // Track the largest occupancy seen since reset or flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hwm <= '0;
        end else if (flush) begin
            hwm <= '0;
        end else if (level_next > hwm) begin
            hwm <= level_next;
        end
    end

    assign max_level = hwm;
`else
    assign max_level = '0;
`endif

endmodule

// File: tb/tb_sync_fifo_stream.sv
// Directed bench for sync_fifo_stream at DEPTH=8, AF=6, AE=2.
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled there too.
// Backpressure: exercises full, overflow, same-edge push+pop when full, flush and async reset.
module tb_sync_fifo_stream;

    localparam int W  = 8;
    localparam int D  = 8;
    localparam int AF = 6;
    localparam int AE = 2;
    localparam int LW = 4;
`ifdef SYNC_FIFO_HWM_EN
    localparam int HWM = 1;
`else
    localparam int HWM = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] level;
    logic          almost_full;
    logic          almost_empty;
    logic          overflow;
    logic [LW-1:0] max_level;

    int n_cmp = 0;
    int n_bad = 0;

    sync_fifo_stream #(
        .WIDTH    (W),
        .DEPTH    (D),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .level        (level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .max_level    (max_level)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int sent;
    int exp_idx;
    bit seen;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #12;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_level", level, 0);
        check_eq("rst_af", almost_full, 0);
        check_eq("rst_ae", almost_empty, 1);
        check_eq("rst_overflow", overflow, 0);
        check_eq("rst_max_level", max_level, 0);

        // First push into empty FIFO appears one cycle later
        rst = 1'b0;
        in_valid = 1'b1; in_data = 8'h11;
        step();
        in_valid = 1'b0;
        check_eq("first_valid", out_valid, 1);
        check_eq("first_data", out_data, 32'h11);
        check_eq("first_level", level, 1);
        check_eq("first_ae", almost_empty, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq("first_pop_level", level, 0);
        check_eq("first_pop_valid", out_valid, 0);

        // Fill to full, watching thresholds
        for (int k = 1; k <= 8; k++) begin
            in_valid = 1'b1; in_data = W'(k);
            step();
            check_eq("fill_level", level, k);
            check_eq("fill_af", almost_full, (k >= AF) ? 1 : 0);
            check_eq("fill_ae", almost_empty, (k <= AE) ? 1 : 0);
        end
        in_valid = 1'b0;
        check_eq("full_in_ready", in_ready, 0);
        check_eq("full_head", out_data, 32'h01);
        check_eq("full_no_ovf", overflow, 0);
        check_eq("full_max_level", max_level, HWM ? 8 : 0);
        in_valid = 1'b1; in_data = 8'h09;
        step();
        in_valid = 1'b0;
        check_eq("ovf_set", overflow, 1);
        check_eq("ovf_level", level, 8);

        // Push and pop at the same edge while full: push is rejected
        in_valid = 1'b1; in_data = 8'h0A; out_ready = 1'b1;
        check_eq("fullpp_in_ready", in_ready, 0);
        check_eq("fullpp_popped", out_data, 32'h01);
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        check_eq("fullpp_level", level, 7);
        check_eq("fullpp_next", out_data, 32'h02);
        check_eq("fullpp_in_ready_after", in_ready, 1);

        // Drain the rest in order
        out_ready = 1'b1;
        for (int k = 2; k <= 8; k++) begin
            check_eq("drain_data", out_data, k);
            step();
        end
        out_ready = 1'b0;
        check_eq("drain_level", level, 0);
        check_eq("drain_valid", out_valid, 0);

        // Continuous stream 0..19 through the RAM path, across pointer wrap
        sent = 0; exp_idx = 0; seen = 1'b0;
        for (int cyc = 0; cyc < 60 && exp_idx < 20; cyc++) begin
            in_valid  = (sent < 20);
            in_data   = W'(sent);
            out_ready = (cyc >= 3);
            if (seen) check_eq("stream_gap", out_valid, 1);
            if (out_valid) seen = 1'b1;
            if (out_valid && out_ready) begin
                check_eq("stream_data", out_data, exp_idx);
                exp_idx++;
            end
            if (in_valid && in_ready) sent++;
            step();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check_eq("stream_count", exp_idx, 20);
        check_eq("stream_level", level, 0);
        check_eq("stream_ovf_sticky", overflow, 1);

        // Flush at level 5 with a simultaneous push
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_data = W'(8'h21 + k);
            step();
        end
        check_eq("preflush_level", level, 5);
        check_eq("preflush_ovf", overflow, 1);
        flush = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check_eq("flush_level", level, 0);
        check_eq("flush_valid", out_valid, 0);
        check_eq("flush_ovf", overflow, 0);
        check_eq("flush_max_level", max_level, 0);
        out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
        check_eq("flush_no_aa_valid", out_valid, 0);
        check_eq("flush_no_aa_level", level, 0);

        // High-water mark: fill to 6, drain to 0
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1; in_data = W'(8'h31 + k);
            step();
        end
        in_valid = 1'b0;
        check_eq("hwm_fill_level", level, 6);
        check_eq("hwm_fill_max", max_level, HWM ? 6 : 0);
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check_eq("hwm_drain_data", out_data, 8'h31 + k);
            step();
        end
        out_ready = 1'b0;
        check_eq("hwm_drain_level", level, 0);
        check_eq("hwm_drain_max", max_level, HWM ? 6 : 0);

        // Asynchronous reset mid-cycle, then first push after release
        in_valid = 1'b1; in_data = 8'h41;
        step();
        in_data = 8'h42;
        step();
        in_valid = 1'b0;
        check_eq("prerst_level", level, 2);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_level", level, 0);
        check_eq("arst_valid", out_valid, 0);
        check_eq("arst_data", out_data, 0);
        check_eq("arst_max", max_level, 0);
        rst = 1'b0;
        in_valid = 1'b1; in_data = 8'h5A;
        step();
        in_valid = 1'b0;
        check_eq("postrst_level", level, 1);
        check_eq("postrst_data", out_data, 32'h5A);
        check_eq("postrst_valid", out_valid, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo_stream.md
# sync_fifo_stream

Parametrised single-clock FIFO with valid/ready handshakes on both sides, a registered first-word-fall-through output stage, programmable almost-full/almost-empty flags, synchronous flush and a sticky overflow flag. It is the successor to the plain UART/command FIFO. It sits between byte/word producers (UART RX, command parser) and consumers (command executor, USB report builder) that need backpressure and a timing-clean output.

## Interface
- `WIDTH`, 8, data width in bits (≥1)
- `DEPTH`, 64, capacity in entries; power of two, ≥2
- `AF_LEVEL`, DEPTH-4, `almost_full` asserts when level ≥ AF_LEVEL (1..DEPTH)
- `AE_LEVEL`, 4, `almost_empty` asserts when level ≤ AE_LEVEL (0..DEPTH-1)
- `LEVEL_W`, $clog2(DEPTH+1), width of level outputs
- `clk` in 1: sole clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `flush` in 1: synchronous clear of all contents
- `in_data` in WIDTH: write data
- `in_valid` in 1: producer offers `in_data`
- `in_ready` out 1: FIFO accepts; = !full
- `out_data` out WIDTH: head entry, registered
- `out_valid` out 1: `out_data` holds a valid entry
- `out_ready` in 1: consumer takes head
- `level` out LEVEL_W: entries held, including the output register
- `almost_full` out 1, `almost_empty` out 1: threshold flags
- `overflow` out 1: sticky, a push was attempted while full
- `max_level` out LEVEL_W: high-water mark (see Configuration)

## Operation
- Push: `in_valid && in_ready` at an edge. Pop: `out_valid && out_ready` at an edge.
- Storage: RAM (DEPTH entries, binary pointers of ADDR_W+1 bits, wrap modulo DEPTH) plus a one-entry output register. Total accepted entries never exceed DEPTH.
- Output register load: at an edge where the output register is empty, or is being popped:
  - If the RAM holds ≥1 entry, load from the RAM head and advance rd_ptr.
  - Else if a push occurs at that edge, load `in_data` directly (bypass; the RAM is not written).
  - Otherwise `out_valid` goes 0.
- `level` is +1 on push only, −1 on pop only, and unchanged on both or neither.
- `full` = (level == DEPTH). `in_ready` = !full. A pop at the same edge does not make room in that cycle; there is no pass-through when full.
- `almost_full` = level ≥ AF_LEVEL. `almost_empty` = level ≤ AE_LEVEL. Both are combinational from the registered `level`.
- `overflow` is set at any edge with `in_valid && !in_ready`. It is cleared only by `rst` or `flush`.
- `flush` takes priority over a simultaneous push or pop. At that edge pointers → 0, level → 0, `out_valid` → 0, `overflow` → 0, and `max_level` → 0. Any push at that edge is discarded and does not set `overflow`.
- `out_data` must hold its value while `out_valid && !out_ready`. When `out_valid` = 0 its value is don't-care.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0, `level`=0, `almost_full`=0 (AF_LEVEL≥1), `almost_empty`=1, `overflow`=0, `max_level`=0.
- Write-to-read latency when empty: a push at edge E gives `out_valid`=1 with that data after E (1 cycle).
- Sustained throughput is one push and one pop per cycle, with no bubbles while level ≥1.
- A pop at edge E with RAM non-empty presents the next entry after E, so there is no gap.
- `rst` asserted mid-operation clears all state asynchronously. The first push is accepted at the first edge after deassertion.
- RAM contents are not reset.

## Configuration
- `SYNC_FIFO_HWM_EN` defined: `max_level` is a register.
  - It updates to the new `level` whenever that value exceeds the current `max_level`.
  - It is cleared by `rst` and `flush`.
- Not defined: `max_level` is tied to 0 and no register is generated.

## Structure
- Shared package `fifo_pkg` holds:
  - a level-width function `fifo_level_w(depth)` returning $clog2(depth+1);
  - elaboration checks that DEPTH is a power of two and that AF_LEVEL/AE_LEVEL are in range.
- One sub-module, `fifo_ram`: simple dual-port RAM with WIDTH×DEPTH, one synchronous write port and one asynchronous read port. All pointer, level and handshake logic stays in `sync_fifo_stream`.

## Test plan
- Reset, then push 0x11 at edge 1 with `out_ready`=0 → after edge 1: `out_valid`=1, `out_data`=0x11, `level`=1, `almost_empty`=1.
- DEPTH=8, AF=6, AE=2: push 0x01..0x08 with no pops → `almost_full` first =1 at level 6; after the 8th push `in_ready`=0. A 9th `in_valid` sets `overflow`=1 and `level` stays 8.
- Full FIFO, push and pop at the same edge → push rejected, `level`=7, popped 0x01, next `out_data`=0x02.
- Continuous push/pop of 0..19 with `out_ready`=1 → out stream 0..19 in order, with no gap after the first valid cycle and correct ordering across pointer wrap.
- Level 5 with `overflow`=1, then assert `flush` with a simultaneous push of 0xAA → next cycle `level`=0, `out_valid`=0, `overflow`=0, and 0xAA never appears.
- With `SYNC_FIFO_HWM_EN`: fill to 6, drain to 0 → `max_level`=6. Without it → `max_level`=0 throughout.
